// File: rtl/stepper_pkg.sv
// Shared types and defaults for the step/dir receive path.
package stepper_pkg;

    typedef logic [23:0] pos_t;
    typedef logic [20:0] delay_t;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } dec_state_t;

    localparam int unsigned TIMEOUT_DEFAULT   = 2_000_000;
    localparam int unsigned MIN_HIGH_DEFAULT  = 50;
    localparam int unsigned DIR_SETUP_DEFAULT = 4;

endpackage

// File: rtl/step_dir_decoder_if.sv
// STEP/DIR sample inputs and position/telemetry outputs of the decoder.
interface step_dir_decoder_if
    import stepper_pkg::*;
#(
    parameter int unsigned POS_W = $bits(pos_t),
    parameter int unsigned PER_W = $bits(delay_t)
);

    logic             step_in;
    logic             dir_in;
    logic             clear;
    logic [POS_W-1:0] position;
    logic             step_strobe;
    logic [PER_W-1:0] step_period;
    logic             period_valid;
    logic             moving;
    logic             pulse_err;
    logic             dir_err;

    modport master (
        output step_in, dir_in, clear,
        input  position, step_strobe, step_period, period_valid,
               moving, pulse_err, dir_err
    );

    modport slave (
        input  step_in, dir_in, clear,
        output position, step_strobe, step_period, period_valid,
               moving, pulse_err, dir_err
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus a delay flop that yields rise/fall/change pulses.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o,
    output logic change_o
);

    logic [2:0] sh_q;
    logic [2:0] sh_d;

    assign sh_d = {sh_q[1:0], d_i};

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign sync_o   = sh_q[1];
    assign rise_o   = sh_q[1] & ~sh_q[2];
    assign fall_o   = ~sh_q[1] & sh_q[2];
    assign change_o = sh_q[1] ^ sh_q[2];

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: position tracking, step period measurement, stall and timing checks.
module step_dir_decoder
    import stepper_pkg::*;
#(
    parameter int unsigned POS_W     = $bits(pos_t),
    parameter int unsigned PER_W     = $bits(delay_t),
    parameter int unsigned MIN_HIGH  = MIN_HIGH_DEFAULT,
    parameter int unsigned DIR_SETUP = DIR_SETUP_DEFAULT,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    step_dir_decoder_if.slave bus
);

    localparam int unsigned WID_W = $clog2(MIN_HIGH + 1);
    localparam int unsigned DS_W  = $clog2(DIR_SETUP + 1);

    localparam logic [WID_W-1:0] WID_MAX   = WID_W'(MIN_HIGH);
    localparam logic [DS_W-1:0]  DS_MAX    = DS_W'(DIR_SETUP);
    localparam logic [PER_W-1:0] PER_TO    = PER_W'(TIMEOUT);
    localparam logic [PER_W-1:0] PER_TO_M1 = PER_W'(TIMEOUT - 1);

    logic step_sync, step_rise, step_fall, step_change;
    logic dir_sync, dir_rise, dir_fall, dir_change;

    sync_edge_detect u_step_sync (
        .clk      (clk),
        .reset    (reset),
        .d_i      (bus.step_in),
        .sync_o   (step_sync),
        .rise_o   (step_rise),
        .fall_o   (step_fall),
        .change_o (step_change)
    );

    sync_edge_detect u_dir_sync (
        .clk      (clk),
        .reset    (reset),
        .d_i      (bus.dir_in),
        .sync_o   (dir_sync),
        .rise_o   (dir_rise),
        .fall_o   (dir_fall),
        .change_o (dir_change)
    );

    logic unused_edges;
    assign unused_edges = ^{step_sync, step_change, dir_rise, dir_fall};

    dec_state_t       state_q, state_d;
    logic [WID_W-1:0] width_q, width_d;
    logic [PER_W-1:0] period_cnt_q, period_cnt_d;
    logic [PER_W-1:0] step_period_q, step_period_d;
    logic [DS_W-1:0]  dir_stable_q, dir_stable_d;
    logic [POS_W-1:0] position_q, position_d;
    logic             period_valid_q, period_valid_d;
    logic             moving_q, moving_d;
    logic             pulse_err_q, pulse_err_d;
    logic             dir_err_q, dir_err_d;
    logic             strobe_q, strobe_d;
    logic             pulse_err_set, dir_err_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            width_q        <= '0;
            period_cnt_q   <= '0;
            step_period_q  <= '0;
            dir_stable_q   <= '0;
            position_q     <= '0;
            period_valid_q <= 1'b0;
            moving_q       <= 1'b0;
            pulse_err_q    <= 1'b0;
            dir_err_q      <= 1'b0;
            strobe_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            width_q        <= width_d;
            period_cnt_q   <= period_cnt_d;
            step_period_q  <= step_period_d;
            dir_stable_q   <= dir_stable_d;
            position_q     <= position_d;
            period_valid_q <= period_valid_d;
            moving_q       <= moving_d;
            pulse_err_q    <= pulse_err_d;
            dir_err_q      <= dir_err_d;
            strobe_q       <= strobe_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        width_d        = width_q;
        period_cnt_d   = period_cnt_q;
        step_period_d  = step_period_q;
        dir_stable_d   = dir_stable_q;
        position_d     = position_q;
        period_valid_d = period_valid_q;
        moving_d       = moving_q;
        strobe_d       = step_rise;
        pulse_err_set  = 1'b0;
        dir_err_set    = 1'b0;

        if (dir_change) begin
            dir_stable_d = '0;
        end else if (dir_stable_q != DS_MAX) begin
            dir_stable_d = dir_stable_q + DS_W'(1);
        end

        // A DIR change landing on the same cycle as the rise is also a setup violation.
        if (step_rise && (dir_change || dir_stable_q < DS_MAX)) begin
            dir_err_set = 1'b1;
        end

        if (bus.clear) begin
            position_d = '0;
        end else if (step_rise) begin
            position_d = dir_sync ? position_q - POS_W'(1) : position_q + POS_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (step_rise) begin
                    state_d      = HIGH;
                    moving_d     = 1'b1;
                    period_cnt_d = PER_W'(1);
                    width_d      = WID_W'(1);
                end
            end
            HIGH, LOW: begin
                if (state_q == HIGH) begin
                    if (step_fall) begin
                        state_d = LOW;
                        if (width_q < WID_MAX) begin
                            pulse_err_set = 1'b1;
                        end
                    end else if (width_q != WID_MAX) begin
                        width_d = width_q + WID_W'(1);
                    end
                end
                // Timeout overrides the HIGH->LOW move so a late fall never masks a stall.
                if (step_rise) begin
                    state_d        = HIGH;
                    width_d        = WID_W'(1);
                    step_period_d  = period_cnt_q;
                    period_valid_d = 1'b1;
                    period_cnt_d   = PER_W'(1);
                end else if (period_cnt_q >= PER_TO_M1) begin
                    state_d        = IDLE;
                    moving_d       = 1'b0;
                    period_valid_d = 1'b0;
                    period_cnt_d   = PER_TO;
                end else begin
                    period_cnt_d = period_cnt_q + PER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        pulse_err_d = pulse_err_set | (pulse_err_q & ~bus.clear);
        dir_err_d   = dir_err_set | (dir_err_q & ~bus.clear);
    end

    assign bus.position     = position_q;
    assign bus.step_strobe  = strobe_q;
    assign bus.step_period  = step_period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.moving       = moving_q;
    assign bus.pulse_err    = pulse_err_q;
    assign bus.dir_err      = dir_err_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder with a strobe-driven scoreboard.
module tb_step_dir_decoder;
    import stepper_pkg::*;

    localparam int unsigned TB_TIMEOUT = 4000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    step_dir_decoder_if #(.POS_W(24), .PER_W(21)) bus ();

    step_dir_decoder #(
        .POS_W     (24),
        .PER_W     (21),
        .MIN_HIGH  (50),
        .DIR_SETUP (4),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [23:0] pos;
        logic        pv;
        logic [20:0] per;
        logic        derr;
        logic        perr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [23:0] pos, input logic pv, input logic [20:0] per,
                        input logic derr, input logic perr);
        exp_t e;
        e.pos  = pos;
        e.pv   = pv;
        e.per  = per;
        e.derr = derr;
        e.perr = perr;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input int high, input int low);
        bus.step_in = 1'b1;
        repeat (high) @(negedge clk);
        bus.step_in = 1'b0;
        repeat (low) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_position"},     32'(bus.position),     32'h0);
        chk({tag, "_step_strobe"},  32'(bus.step_strobe),  32'h0);
        chk({tag, "_step_period"},  32'(bus.step_period),  32'h0);
        chk({tag, "_period_valid"}, 32'(bus.period_valid), 32'h0);
        chk({tag, "_moving"},       32'(bus.moving),       32'h0);
        chk({tag, "_pulse_err"},    32'(bus.pulse_err),    32'h0);
        chk({tag, "_dir_err"},      32'(bus.dir_err),      32'h0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && bus.step_strobe) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe: got strobe, expected none (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_position",     32'(bus.position),     32'(e.pos));
                chk("strobe_period_valid", 32'(bus.period_valid), 32'(e.pv));
                chk("strobe_step_period",  32'(bus.step_period),  32'(e.per));
                chk("strobe_dir_err",      32'(bus.dir_err),      32'(e.derr));
                chk("strobe_pulse_err",    32'(bus.pulse_err),    32'(e.perr));
                chk("strobe_moving",       32'(bus.moving),       32'h1);
            end
        end
    end

    initial begin
        int n;
        reset       = 1'b1;
        bus.step_in = 1'b0;
        bus.dir_in  = 1'b0;
        bus.clear   = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Forward steps at period 625; first rise only arms the measurement.
        for (int i = 0; i < 10; i++) begin
            push(24'(i + 1), (i > 0), (i > 0) ? 21'd625 : 21'd0, 1'b0, 1'b0);
            pulse(100, 525);
        end
        chk("fwd_position", 32'(bus.position), 32'd10);
        chk("fwd_period", 32'(bus.step_period), 32'd625);
        chk("fwd_period_valid", 32'(bus.period_valid), 32'h1);
        push(24'd11, 1'b1, 21'd625, 1'b0, 1'b0);
        pulse(50, 575);
        chk("min_high_legal", 32'(bus.pulse_err), 32'h0);

        // Reverse steps, DIR settled long before the rise.
        bus.dir_in = 1'b1;
        repeat (1000) @(negedge clk);
        push(24'd10, 1'b1, 21'd1625, 1'b0, 1'b0);
        pulse(100, 525);
        for (int i = 0; i < 3; i++) begin
            push(24'(9 - i), 1'b1, 21'd625, 1'b0, 1'b0);
            pulse(100, 525);
        end
        chk("rev_position", 32'(bus.position), 32'd7);
        chk("rev_dir_err", 32'(bus.dir_err), 32'h0);

        // DIR change 2 clks before the rise.
        bus.dir_in = 1'b0;
        repeat (300) @(negedge clk);
        bus.dir_in = 1'b1;
        repeat (2) @(negedge clk);
        push(24'd6, 1'b1, 21'd927, 1'b1, 1'b0);
        pulse(100, 525);
        chk("setup_dir_err", 32'(bus.dir_err), 32'h1);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clear_position", 32'(bus.position), 32'h0);
        chk("clear_dir_err", 32'(bus.dir_err), 32'h0);
        chk("clear_keeps_moving", 32'(bus.moving), 32'h1);
        chk("clear_keeps_period", 32'(bus.step_period), 32'd927);

        // Short pulse, then stall.
        push(24'hFFFFFF, 1'b1, 21'd626, 1'b0, 1'b0);
        pulse(20, 605);
        chk("short_pulse_err", 32'(bus.pulse_err), 32'h1);
        n = 0;
        while (bus.moving === 1'b1 && n < 3 * TB_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n < int'(TB_TIMEOUT) - 630 || n > int'(TB_TIMEOUT) - 618) begin
            n_err++;
            $display("FAIL stall_latency: got %0d clks, expected about %0d", n, TB_TIMEOUT - 623);
        end
        chk("stall_moving", 32'(bus.moving), 32'h0);
        chk("stall_period_valid", 32'(bus.period_valid), 32'h0);
        chk("stall_keeps_period", 32'(bus.step_period), 32'd626);
        chk("stall_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Wrap FFFFFF -> 0, then clear coinciding with the detected rise.
        bus.dir_in = 1'b0;
        repeat (10) @(negedge clk);
        push(24'h000000, 1'b0, 21'd626, 1'b0, 1'b1);
        pulse(100, 525);
        push(24'h000000, 1'b1, 21'd625, 1'b0, 1'b0);
        bus.step_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        repeat (97) @(negedge clk);
        bus.step_in = 1'b0;
        repeat (525) @(negedge clk);
        chk("clear_rise_position", 32'(bus.position), 32'h0);
        chk("clear_rise_pulse_err", 32'(bus.pulse_err), 32'h0);

        // Reset in the middle of a HIGH phase at period 781.
        push(24'd1, 1'b1, 21'd625, 1'b0, 1'b0);
        pulse(100, 681);
        push(24'd2, 1'b1, 21'd781, 1'b0, 1'b0);
        bus.step_in = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        bus.step_in = 1'b0;
        repeat (50) @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        repeat (631) @(negedge clk);
        push(24'd1, 1'b0, 21'd0, 1'b0, 1'b0);
        pulse(100, 681);
        push(24'd2, 1'b1, 21'd781, 1'b0, 1'b0);
        pulse(100, 681);

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
